// File: rtl/rng_pkg.sv
// Shared constants for the random-number buffering path.
package rng_pkg;
   localparam int RNG_DATA_W     = 8;
   localparam int RNG_FIFO_DEPTH = 16;
endpackage

// File: rtl/rng_fifo_mem.sv
// Storage array for rng_fifo: one synchronous write port and one asynchronous read port.
module rng_fifo_mem
   import rng_pkg::*;
#(
   parameter int DATA_W = RNG_DATA_W,
   parameter int DEPTH  = RNG_FIFO_DEPTH
) (
   input  logic                       clk_i,
   input  logic                       we,
   input  logic [$clog2(DEPTH)-1:0]   waddr,
   input  logic [DATA_W-1:0]          wdata,
   input  logic [$clog2(DEPTH)-1:0]   raddr,
   output logic [DATA_W-1:0]          rdata
);
   logic [DATA_W-1:0] mem_r [DEPTH];

   // Contents are deliberately not reset; the owning FIFO resets its pointers instead.
   always_ff @(posedge clk_i) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   assign rdata = mem_r[raddr];
endmodule

// File: rtl/rng_fifo.sv
// First-word-fall-through FIFO for random words; pointers, occupancy and
// sticky error flags live here, storage lives in rng_fifo_mem.
module rng_fifo
   import rng_pkg::*;
#(
   parameter int DATA_W = RNG_DATA_W,
   parameter int DEPTH  = RNG_FIFO_DEPTH
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     write,
   input  logic [DATA_W-1:0]        data_in,
   input  logic                     read,
   output logic [DATA_W-1:0]        data_out,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     underflow
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [CNT_W-1:0]  count_r;
   logic              overflow_r;
   logic              underflow_r;
   logic              empty_s;
   logic              full_s;
   logic              wr_en_s;
   logic              rd_en_s;
   logic [DATA_W-1:0] rdata_s;

   // Occupancy flags come from the registered count so a wrapped pointer pair is never ambiguous.
   assign empty_s = (count_r == {CNT_W{1'b0}});
   assign full_s  = (count_r == CNT_W'(DEPTH));
   assign wr_en_s = write & ~full_s & ~rst_i;
   assign rd_en_s = read & ~empty_s & ~rst_i;

   rng_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk_i (clk_i),
      .we    (wr_en_s),
      .waddr (wr_ptr_r),
      .wdata (data_in),
      .raddr (rd_ptr_r),
      .rdata (rdata_s)
   );

   // Pointer, occupancy and sticky-flag state; reset wins over any request.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_r    <= {PTR_W{1'b0}};
         rd_ptr_r    <= {PTR_W{1'b0}};
         count_r     <= {CNT_W{1'b0}};
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else begin
         if (wr_en_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (rd_en_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({wr_en_s, rd_en_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
         if (write & full_s) begin
            overflow_r <= 1'b1;
         end
         if (read & empty_s) begin
            underflow_r <= 1'b1;
         end
      end
   end

   assign data_out  = empty_s ? {DATA_W{1'b0}} : rdata_s;
   assign empty     = empty_s;
   assign full      = full_s;
   assign count     = count_r;
   assign overflow  = overflow_r;
   assign underflow = underflow_r;
endmodule

// File: tb/tb_rng_fifo.sv
// Randomized and directed bench for rng_fifo against a queue-based reference model.
module tb_rng_fifo;
   logic       clk_i = 1'b0;
   logic       rst_i = 1'b0;
   logic       write = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       read = 1'b0;
   logic [7:0] data_out;
   logic       empty;
   logic       full;
   logic [4:0] count;
   logic       overflow;
   logic       underflow;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] mq[$];
   logic       m_ovf = 1'b0;
   logic       m_unf = 1'b0;
   logic [3:0] m_wa = 4'd0;
   logic [3:0] m_ra = 4'd0;

   logic [16:0] dut_vec;
   assign dut_vec = {data_out, count, empty, full, overflow, underflow};

   rng_fifo dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .write     (write),
      .data_in   (data_in),
      .read      (read),
      .data_out  (data_out),
      .empty     (empty),
      .full      (full),
      .count     (count),
      .overflow  (overflow),
      .underflow (underflow)
   );

   always #5 clk_i = ~clk_i;

   // Expected {data_out, count, empty, full, overflow, underflow} from the model queue.
   function automatic logic [16:0] model_vec();
      logic [7:0] d;
      d = (mq.size() > 0) ? mq[0] : 8'h00;
      return {d, 5'(mq.size()), (mq.size() == 0), (mq.size() == 16), m_ovf, m_unf};
   endfunction

   // Apply one cycle of stimulus and advance the reference model by the FIFO rules.
   task automatic step(input logic r_st, input logic w, input logic [7:0] d, input logic r);
      logic wacc;
      logic racc;
      rst_i = r_st; write = w; data_in = d; read = r;
      @(posedge clk_i);
      if (r_st) begin
         mq.delete();
         m_ovf = 1'b0; m_unf = 1'b0; m_wa = 4'd0; m_ra = 4'd0;
      end else begin
         wacc = w && (mq.size() < 16);
         racc = r && (mq.size() > 0);
         if (racc) begin
            void'(mq.pop_front());
            m_ra = m_ra + 4'd1;
         end
         if (wacc) begin
            mq.push_back(d);
            m_wa = m_wa + 4'd1;
         end
         if (w && !wacc) m_ovf = 1'b1;
         if (r && !racc) m_unf = 1'b1;
      end
      #1;
      rst_i = 1'b0; write = 1'b0; read = 1'b0;
   endtask

   task automatic test_reset();
      step(1'b1, 1'b1, 8'h33, 1'b1);
      n_cmp++;
      if (dut_vec !== {8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL reset_state: got %h expected %h", dut_vec, {8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0});
      end
   endtask

   task automatic test_single_write();
      step(1'b1, 1'b0, 8'h00, 1'b0);
      step(1'b0, 1'b1, 8'hAA, 1'b0);
      n_cmp++;
      if ({data_out, count, empty} !== {8'hAA, 5'd1, 1'b0}) begin
         n_err++;
         $display("FAIL single_write: got data=%h count=%0d empty=%b expected data=aa count=1 empty=0",
                  data_out, count, empty);
      end
   endtask

   task automatic test_two_then_read();
      logic [7:0] exp_d [3];
      exp_d[0] = 8'hFF; exp_d[1] = 8'h00; exp_d[2] = 8'h00;
      step(1'b1, 1'b0, 8'h00, 1'b0);
      step(1'b0, 1'b1, 8'hAA, 1'b0);
      step(1'b0, 1'b1, 8'hFF, 1'b0);
      n_cmp++;
      if (data_out !== 8'hAA || count !== 5'd2) begin
         n_err++;
         $display("FAIL two_writes: got data=%h count=%0d expected data=aa count=2", data_out, count);
      end
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 1'b0, 8'h00, 1'b1);
         n_cmp++;
         if (data_out !== exp_d[i] || count !== 5'(1 - i)) begin
            n_err++;
            $display("FAIL read_order_%0d: got data=%h count=%0d expected data=%h count=%0d",
                     i, data_out, count, exp_d[i], 1 - i);
         end
      end
      n_cmp++;
      if (empty !== 1'b1) begin
         n_err++;
         $display("FAIL drained_empty: got %b expected 1", empty);
      end
   endtask

   task automatic test_fill_hold();
      step(1'b1, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b1, (i == 0) ? 8'hAA : 8'hFF, 1'b0);
         n_cmp++;
         if (full !== (i >= 15) || dut_vec !== model_vec()) begin
            n_err++;
            $display("FAIL fill_edge_%0d: got full=%b vec=%h expected full=%b vec=%h",
                     i + 1, full, dut_vec, (i >= 15), model_vec());
         end
      end
      n_cmp++;
      if ({data_out, count, full, overflow} !== {8'hAA, 5'd16, 1'b1, 1'b1}) begin
         n_err++;
         $display("FAIL fill_final: got data=%h count=%0d full=%b ovf=%b expected aa 16 1 1",
                  data_out, count, full, overflow);
      end
   endtask

   task automatic test_underflow();
      step(1'b1, 1'b0, 8'h00, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      n_cmp++;
      if ({underflow, count, empty} !== {1'b1, 5'd0, 1'b1} || dut.rd_ptr_r !== 4'd0) begin
         n_err++;
         $display("FAIL underflow: got unf=%b count=%0d empty=%b rd_ptr=%0d expected 1 0 1 0",
                  underflow, count, empty, dut.rd_ptr_r);
      end
      step(1'b0, 1'b1, 8'h42, 1'b1);
      n_cmp++;
      if (dut_vec !== model_vec() || data_out !== 8'h42) begin
         n_err++;
         $display("FAIL empty_wr_rd: got %h expected %h", dut_vec, model_vec());
      end
   endtask

   task automatic test_full_rw();
      logic [7:0] second;
      step(1'b1, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'($urandom), 1'b0);
      second = mq[1];
      step(1'b0, 1'b1, 8'h77, 1'b1);
      n_cmp++;
      if ({count, overflow, data_out} !== {5'd15, 1'b1, second}) begin
         n_err++;
         $display("FAIL full_wr_rd: got count=%0d ovf=%b data=%h expected 15 1 %h",
                  count, overflow, data_out, second);
      end
      for (int i = 0; i < 32; i++) begin
         step(1'b0, 1'b1, 8'($urandom), 1'b1);
         n_cmp++;
         if (dut_vec !== model_vec() || dut.wr_ptr_r !== m_wa || dut.rd_ptr_r !== m_ra) begin
            n_err++;
            $display("FAIL pair_%0d: got vec=%h wr=%0d rd=%0d expected vec=%h wr=%0d rd=%0d",
                     i, dut_vec, dut.wr_ptr_r, dut.rd_ptr_r, model_vec(), m_wa, m_ra);
         end
      end
   endtask

   task automatic test_reset_midfill();
      step(1'b1, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(i + 1), 1'b1);
      step(1'b1, 1'b1, 8'hEE, 1'b0);
      n_cmp++;
      if (dut_vec !== {8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL midfill_reset: got %h expected %h", dut_vec, {8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0});
      end
      step(1'b0, 1'b1, 8'h5A, 1'b0);
      n_cmp++;
      if (data_out !== 8'h5A || dut.u_mem.mem_r[0] !== 8'h5A || dut.wr_ptr_r !== 4'd1) begin
         n_err++;
         $display("FAIL post_reset_addr0: got data=%h mem0=%h wr_ptr=%0d expected 5a 5a 1",
                  data_out, dut.u_mem.mem_r[0], dut.wr_ptr_r);
      end
   endtask

   task automatic test_random();
      int pw;
      step(1'b1, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 600; i++) begin
         pw = ((i / 100) % 2 == 0) ? 70 : 30;
         step(($urandom_range(127) == 0), ($urandom_range(99) < pw), 8'($urandom),
              ($urandom_range(99) < 50));
         n_cmp++;
         if (dut_vec !== model_vec() || dut.wr_ptr_r !== m_wa || dut.rd_ptr_r !== m_ra) begin
            n_err++;
            $display("FAIL random_%0d: got vec=%h wr=%0d rd=%0d expected vec=%h wr=%0d rd=%0d",
                     i, dut_vec, dut.wr_ptr_r, dut.rd_ptr_r, model_vec(), m_wa, m_ra);
         end
      end
   endtask

   initial begin
      #2;
      test_reset();
      test_single_write();
      test_two_then_read();
      test_fill_hold();
      test_underflow();
      test_full_rw();
      test_reset_midfill();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
